// File: rtl/spi_pkg.sv
// Shared types and helpers for the multi-byte SPI master.
// Mode constants are {cpol, cpha}.
package spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StDone
    } spi_state_e;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // Clocks from the accept cycle to the o_done cycle, inclusive of the accept cycle.
    function automatic int unsigned transfer_cycles(input int unsigned clk_div,
                                                    input int unsigned cs_setup,
                                                    input int unsigned cs_hold,
                                                    input int unsigned n_bytes);
        return clk_div * (cs_setup + 16 * n_bytes + cs_hold) + 1;
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator: one-cycle pulse every CLK_DIV enabled cycles.
// The counter wraps CLK_DIV-1 -> 0 and is forced to 0 while cleared.
module spi_tick_gen #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_tick
);

    localparam int unsigned CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_wrap;

    assign at_wrap = (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_enable) begin
            cnt_d = at_wrap ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = i_enable && !i_clear && at_wrap;

endmodule

// File: rtl/spi_master_multi.sv
// Single-clock SPI master: 1..MAX_BYTES bytes per transfer, all CPOL/CPHA modes,
// programmable CS setup/hold in SCLK half-periods. All pin outputs are registered.
module spi_master_multi
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 25,
    parameter int unsigned MAX_BYTES = 4,
    parameter int unsigned CS_SETUP  = 2,
    parameter int unsigned CS_HOLD   = 2,
    parameter int unsigned NB_W      = $clog2(MAX_BYTES + 1)
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_start,
    input  logic                   i_cpol,
    input  logic                   i_cpha,
    input  logic [NB_W-1:0]        i_num_bytes,
    input  logic [8*MAX_BYTES-1:0] i_tx_data,
    output logic [8*MAX_BYTES-1:0] o_rx_data,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_cs_n,
    output logic                   o_sclk,
    output logic                   o_mosi,
    input  logic                   i_miso
);

    localparam int unsigned DW     = 8 * MAX_BYTES;
    localparam int unsigned BC_W   = $clog2(16 * MAX_BYTES + 1);
    localparam int unsigned HP_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned HP_W   = (HP_MAX > 1) ? $clog2(HP_MAX) : 1;

    spi_state_e      state_q, state_d;
    logic            cpol_q, cpol_d;
    logic            cpha_q, cpha_d;
    logic [NB_W-1:0] n_q, n_d;
    logic [DW-1:0]   tx_q, tx_d;
    logic [DW-1:0]   rx_shift_q, rx_shift_d;
    logic [DW-1:0]   rx_data_q, rx_data_d;
    logic [HP_W-1:0] hp_q, hp_d;
    logic [BC_W-1:0] edge_q, edge_d;
    logic            cs_n_q, cs_n_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;

    logic            tick;
    logic [NB_W-1:0] n_in;
    logic [DW-1:0]   tx_aligned;
    logic [BC_W-1:0] edge_next;
    logic [BC_W-1:0] edges_total;
    logic            sample_edge;
    logic            shift_edge;

    assign o_busy = (state_q == StSetup) || (state_q == StShift) || (state_q == StHold);

    spi_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_enable(o_busy),
        .i_clear (!o_busy),
        .o_tick  (tick)
    );

    // Edge numbering starts at 1; odd edges are leading edges.
    always_comb begin
        n_in        = (i_num_bytes > NB_W'(MAX_BYTES)) ? NB_W'(MAX_BYTES) : i_num_bytes;
        tx_aligned  = i_tx_data << (8 * (MAX_BYTES - 32'(n_in)));
        edge_next   = edge_q + BC_W'(1);
        edges_total = BC_W'({n_q, 4'b0000});
        sample_edge = cpha_q ? !edge_next[0] : edge_next[0];
        // CPHA=1 already presents the first bit, so its first leading edge does not shift.
        shift_edge  = cpha_q ? (edge_next[0] && (edge_q != '0))
                             : (!edge_next[0] && (edge_next != edges_total));
    end

    always_comb begin
        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        n_d        = n_q;
        tx_d       = tx_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        hp_d       = hp_q;
        edge_d     = edge_q;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;

        unique case (state_q)
            StIdle: begin
                cs_n_d = 1'b1;
                sclk_d = cpol_q;
                if (i_enable && i_start && (i_num_bytes != '0)) begin
                    state_d    = StSetup;
                    cpol_d     = i_cpol;
                    cpha_d     = i_cpha;
                    n_d        = n_in;
                    tx_d       = tx_aligned;
                    mosi_d     = tx_aligned[DW-1];
                    rx_shift_d = '0;
                    hp_d       = '0;
                    edge_d     = '0;
                    cs_n_d     = 1'b0;
                    sclk_d     = i_cpol;
                end
            end
            StSetup: begin
                if (tick) begin
                    if (hp_q == HP_W'(CS_SETUP - 1)) begin
                        state_d = StShift;
                        hp_d    = '0;
                    end else begin
                        hp_d = hp_q + HP_W'(1);
                    end
                end
            end
            StShift: begin
                if (tick) begin
                    sclk_d = !sclk_q;
                    edge_d = edge_next;
                    if (sample_edge) begin
                        rx_shift_d = {rx_shift_q[DW-2:0], i_miso};
                    end
                    if (shift_edge) begin
                        tx_d   = tx_q << 1;
                        mosi_d = tx_q[DW-2];
                    end
                    if (edge_next == edges_total) begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                sclk_d = cpol_q;
                if (tick) begin
                    if (hp_q == HP_W'(CS_HOLD - 1)) begin
                        state_d   = StDone;
                        hp_d      = '0;
                        cs_n_d    = 1'b1;
                        rx_data_d = rx_shift_q;
                    end else begin
                        hp_d = hp_q + HP_W'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= StIdle;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            n_q        <= '0;
            tx_q       <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            hp_q       <= '0;
            edge_q     <= '0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            n_q        <= n_d;
            tx_q       <= tx_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            hp_q       <= hp_d;
            edge_q     <= edge_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
        end
    end

    assign o_done    = (state_q == StDone);
    assign o_rx_data = rx_data_q;
    assign o_cs_n    = cs_n_q;
    assign o_sclk    = sclk_q;
    assign o_mosi    = mosi_q;

endmodule
